// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state
// encoding, default widths and a small counter-width helper.
package mips_mem_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  // Who currently owns the memory port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Priority decision between the fetch (I) and data (D) requesters, plus the
// saturating counter that bounds how long a waiting fetch can be passed over.
// D normally wins; once STARVE_MAX D grants have gone by with a fetch
// waiting, the fetch is forced through. STARVE_MAX = 0 means D always wins.
module mem_arb_pick
  import mips_mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic arb_en,   // a grant may be issued this cycle
  input  logic idle,     // no transaction in flight
  input  logic i_req,
  input  logic d_req,
  output logic pick_i,
  output logic pick_d
);

  localparam int               CNT_W    = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);
  localparam bit               NO_LIMIT = (STARVE_MAX == 0);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             d_allowed;

  // D may overtake a waiting fetch only while the starvation budget remains.
  assign d_allowed = NO_LIMIT || (starve_q < CNT_MAX);
  assign pick_d    = arb_en & d_req & (~i_req | d_allowed);
  assign pick_i    = arb_en & i_req & ~pick_d;

  // Next starvation count: clear on a fetch grant or when no fetch waits in
  // IDLE, count up (saturating) on every D grant that bypasses a fetch.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the signal
    // unassigned; an unassigned path would infer a latch.
    starve_d = starve_q;
    if (pick_i) begin
      starve_d = '0;
    end else if (pick_d && i_req) begin
      if (starve_q != CNT_MAX) starve_d = starve_q + CNT_W'(1);
    end else if (idle && !i_req) begin
      starve_d = '0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order.
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch stage (I) and the memory
// stage (D). One command is in flight at a time; it is issued on m_req with
// a registered payload and completes on m_ack, after which the owning port
// gets a one-cycle rvalid pulse carrying the registered read data. A new
// grant is made in the ack cycle so a waiting request follows without a gap.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clock,
  input  logic                reset,
  // fetch port
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  // data port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // memory side
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata,
  // pipeline stalls
  output logic                fetch_stall,
  output logic                mem_stall
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  logic              i_gnt_q, i_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [BE_W-1:0]   m_be_q, m_be_d;
  logic              i_rvalid_q, i_rvalid_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              flush_pend_q, flush_pend_d;

  logic busy;
  logic arb_en;
  logic pick_i;
  logic pick_d;

  // An ack only means something while a command is out; in IDLE it is
  // ignored, which also drops a late ack from a command killed by reset.
  assign busy   = (state_q != ST_IDLE);
  assign arb_en = ~busy | m_ack;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clock  (clock),
    .reset  (reset),
    .arb_en (arb_en),
    .idle   (~busy),
    .i_req  (i_req),
    .d_req  (d_req),
    .pick_i (pick_i),
    .pick_d (pick_d)
  );

  // Next state, grant/payload capture and response generation.
  always_comb begin
    state_d      = state_q;
    i_gnt_d      = 1'b0;
    d_gnt_d      = 1'b0;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_be_d       = m_be_q;
    i_rvalid_d   = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rvalid_d   = 1'b0;
    d_rdata_d    = d_rdata_q;
    flush_pend_d = flush_pend_q;

    // Fetch completion; a redirect seen at any point of the fetch, the ack
    // cycle included, discards its data but lets the memory cycle finish.
    if (state_q == ST_BUSY_I) begin
      if (m_ack) begin
        flush_pend_d = 1'b0;
        if (!(flush_pend_q || i_flush)) begin
          i_rvalid_d = 1'b1;
          i_rdata_d  = m_rdata;
        end
      end else if (i_flush) begin
        flush_pend_d = 1'b1;
      end
    end

    // Data completion; stores report zero read data.
    if (state_q == ST_BUSY_D && m_ack) begin
      d_rvalid_d = 1'b1;
      d_rdata_d  = m_we_q ? '0 : m_rdata;
    end

    // Arbitration in IDLE or in the ack cycle of the current owner.
    if (arb_en) begin
      state_d = ST_IDLE;
      if (pick_d) begin
        state_d   = ST_BUSY_D;
        d_gnt_d   = 1'b1;
        m_we_d    = d_we;
        m_addr_d  = d_addr;
        m_wdata_d = d_we ? d_wdata : '0;
        m_be_d    = d_we ? d_be : '1;
      end else if (pick_i) begin
        state_d   = ST_BUSY_I;
        i_gnt_d   = 1'b1;
        m_we_d    = 1'b0;
        m_addr_d  = i_addr;
        m_wdata_d = '0;
        m_be_d    = '1;
      end
    end
  end

  // Ownership state; reset aborts any command so m_req drops at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Grant pulses and the memory command payload, held while m_req is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_gnt_q   <= 1'b0;
      d_gnt_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
    end else begin
      i_gnt_q   <= i_gnt_d;
      d_gnt_q   <= d_gnt_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
    end
  end

  // Response pulses, returned data and the pending-flush marker.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_rvalid_q   <= 1'b0;
      i_rdata_q    <= '0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      i_rvalid_q   <= i_rvalid_d;
      i_rdata_q    <= i_rdata_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign i_gnt       = i_gnt_q;
  assign i_rvalid    = i_rvalid_q;
  assign i_rdata     = i_rdata_q;
  assign d_gnt       = d_gnt_q;
  assign d_rvalid    = d_rvalid_q;
  assign d_rdata     = d_rdata_q;
  assign m_req       = busy;
  assign m_we        = m_we_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign m_be        = m_be_q;
  assign fetch_stall = i_req & ~i_rvalid_q;
  assign mem_stall   = d_req & ~d_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The bench plays both pipeline
// requesters and the memory. Inputs change 1 time unit after a rising edge
// and outputs are sampled at that same point, so "cycle n" below is the
// interval after the n-th edge counted from the start of each scenario.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req, i_flush;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        fetch_stall, mem_stall;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_flush     (i_flush),
    .i_gnt       (i_gnt),
    .i_rvalid    (i_rvalid),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_be        (d_be),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .m_req       (m_req),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_be        (m_be),
    .m_ack       (m_ack),
    .m_rdata     (m_rdata),
    .fetch_stall (fetch_stall),
    .mem_stall   (mem_stall)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_flush = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    m_ack = 1'b0; m_rdata = '0;

    // ---- reset state
    cyc();
    cyc();
    chk_bit ("rst i_gnt",    i_gnt,    1'b0);
    chk_bit ("rst d_gnt",    d_gnt,    1'b0);
    chk_bit ("rst m_req",    m_req,    1'b0);
    chk_bit ("rst i_rvalid", i_rvalid, 1'b0);
    chk_bit ("rst d_rvalid", d_rvalid, 1'b0);
    chk_word("rst m_addr",   m_addr,   32'h0);
    chk_word("rst i_rdata",  i_rdata,  32'h0);
    chk_word("rst d_rdata",  d_rdata,  32'h0);
    reset = 1'b0;

    // ---- lone fetch: req c0, gnt c1, ack c2, rvalid c3
    i_req = 1'b1; i_addr = 32'h40;
    cyc();                                                    // c1
    chk_bit ("lone i_gnt",    i_gnt,    1'b1);
    chk_bit ("lone m_req",    m_req,    1'b1);
    chk_word("lone m_addr",   m_addr,   32'h40);
    chk_bit ("lone m_we",     m_we,     1'b0);
    chk_word("lone m_be",     32'(m_be), 32'hF);
    chk_bit ("lone stall c1", fetch_stall, 1'b1);
    cyc();                                                    // c2
    chk_bit ("lone gnt pulse", i_gnt, 1'b0);
    chk_bit ("lone m_req c2",  m_req, 1'b1);
    // requester withdraws in the ack cycle; the fetch still completes
    m_ack = 1'b1; m_rdata = 32'h8C220004; i_req = 1'b0;
    cyc();                                                    // c3
    m_ack = 1'b0;
    chk_bit ("lone i_rvalid", i_rvalid, 1'b1);
    chk_word("lone i_rdata",  i_rdata,  32'h8C220004);
    chk_bit ("lone stall c3", fetch_stall, 1'b0);
    chk_bit ("lone m_req c3", m_req, 1'b0);
    chk_bit ("lone d_rvalid", d_rvalid, 1'b0);
    cyc();                                                    // c4
    chk_bit ("lone rvalid pulse", i_rvalid, 1'b0);

    // ---- collision: D load wins, I granted right after the D ack
    i_req = 1'b1; i_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    cyc();                                                    // c1
    chk_bit ("col d_gnt",  d_gnt, 1'b1);
    chk_bit ("col i_gnt",  i_gnt, 1'b0);
    chk_word("col m_addr", m_addr, 32'h100);
    chk_bit ("col mem_stall c1", mem_stall, 1'b1);
    m_ack = 1'b1; m_rdata = 32'h11223344; d_req = 1'b0;       // ack c1
    cyc();                                                    // c2
    chk_bit ("col i_gnt c2",    i_gnt,    1'b1);
    chk_bit ("col d_gnt c2",    d_gnt,    1'b0);
    chk_bit ("col d_rvalid",    d_rvalid, 1'b1);
    chk_word("col d_rdata",     d_rdata,  32'h11223344);
    chk_word("col m_addr c2",   m_addr,   32'h44);
    chk_bit ("col mem_stall",   mem_stall, 1'b0);
    chk_bit ("col fetch_stall", fetch_stall, 1'b1);
    m_rdata = 32'hA5A5_5A5A; i_req = 1'b0;                    // ack c2
    cyc();                                                    // c3
    m_ack = 1'b0;
    chk_bit ("col i_rvalid",   i_rvalid, 1'b1);
    chk_word("col i_rdata",    i_rdata,  32'hA5A5_5A5A);
    chk_bit ("col d_rvalid c3", d_rvalid, 1'b0);
    chk_bit ("col m_req c3",   m_req,    1'b0);

    // ---- starvation: 4 back-to-back loads, then the fetch, then D again
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000;
    for (int k = 0; k < 4; k++) begin
      cyc();                                                  // c1..c4
      chk_bit ("stv d_gnt",  d_gnt, 1'b1);
      chk_bit ("stv i_gnt",  i_gnt, 1'b0);
      chk_word("stv m_addr", m_addr, 32'h1000 + 32'(4 * k));
      if (k > 0) begin
        chk_bit ("stv d_rvalid", d_rvalid, 1'b1);
        chk_word("stv d_rdata",  d_rdata,  32'(k - 1));
      end
      // ack now and present the next load in the same cycle
      m_ack = 1'b1; m_rdata = 32'(k);
      d_addr = 32'h1000 + 32'(4 * (k + 1));
    end
    cyc();                                                    // c5
    chk_bit ("stv forced i_gnt", i_gnt, 1'b1);
    chk_bit ("stv d_gnt c5",     d_gnt, 1'b0);
    chk_word("stv m_addr c5",    m_addr, 32'h200);
    chk_bit ("stv d_rvalid c5",  d_rvalid, 1'b1);
    chk_word("stv d_rdata c5",   d_rdata,  32'h3);
    m_rdata = 32'h0BAD_F00D;
    cyc();                                                    // c6
    chk_bit ("stv d_gnt again",  d_gnt, 1'b1);
    chk_word("stv m_addr c6",    m_addr, 32'h1010);
    chk_bit ("stv i_rvalid",     i_rvalid, 1'b1);
    chk_word("stv i_rdata",      i_rdata,  32'h0BAD_F00D);
    i_req = 1'b0; d_req = 1'b0; m_rdata = 32'h55;
    cyc();                                                    // c7
    m_ack = 1'b0;
    chk_bit ("stv last d_rvalid", d_rvalid, 1'b1);
    chk_word("stv last d_rdata",  d_rdata,  32'h55);
    chk_bit ("stv m_req c7",      m_req,    1'b0);

    // ---- flush: idle flush is harmless, in-flight fetch is discarded
    i_flush = 1'b1;
    cyc();
    i_flush = 1'b0;
    chk_bit ("fl idle m_req", m_req, 1'b0);
    i_req = 1'b1; i_addr = 32'h60;
    cyc();                                                    // c1
    chk_bit ("fl i_gnt",  i_gnt, 1'b1);
    chk_word("fl m_addr", m_addr, 32'h60);
    i_flush = 1'b1; i_addr = 32'h80;                          // redirect
    cyc();                                                    // c2
    i_flush = 1'b0;
    chk_bit ("fl m_req c2",    m_req,    1'b1);
    chk_bit ("fl i_rvalid c2", i_rvalid, 1'b0);
    m_ack = 1'b1; m_rdata = 32'hFFFF_0000;
    cyc();                                                    // c3
    chk_bit ("fl suppressed",  i_rvalid, 1'b0);
    chk_bit ("fl i_gnt 0x80",  i_gnt,    1'b1);
    chk_word("fl m_addr 0x80", m_addr,   32'h80);
    chk_bit ("fl fetch_stall", fetch_stall, 1'b1);
    m_rdata = 32'h1234_5678; i_req = 1'b0;
    cyc();                                                    // c4
    m_ack = 1'b0;
    chk_bit ("fl i_rvalid 0x80", i_rvalid, 1'b1);
    chk_word("fl i_rdata 0x80",  i_rdata,  32'h1234_5678);
    cyc();
    chk_bit ("fl rvalid pulse", i_rvalid, 1'b0);

    // ---- store: payload captured at grant, d_rdata 0 on completion
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300;
    d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    cyc();                                                    // c1
    chk_bit ("st d_gnt",   d_gnt, 1'b1);
    chk_bit ("st m_we",    m_we,  1'b1);
    chk_word("st m_be",    32'(m_be), 32'h3);
    chk_word("st m_wdata", m_wdata, 32'hDEAD_BEEF);
    chk_word("st m_addr",  m_addr,  32'h300);
    d_wdata = 32'h0; d_be = 4'hF;
    cyc();                                                    // c2
    chk_word("st m_wdata held", m_wdata, 32'hDEAD_BEEF);
    chk_word("st m_be held",    32'(m_be), 32'h3);
    chk_bit ("st m_req held",   m_req, 1'b1);
    m_ack = 1'b1; m_rdata = 32'h7777_7777; d_req = 1'b0;
    cyc();                                                    // c3
    m_ack = 1'b0;
    chk_bit ("st d_rvalid", d_rvalid, 1'b1);
    chk_word("st d_rdata",  d_rdata,  32'h0);
    chk_bit ("st m_req c3", m_req,    1'b0);

    // ---- stray ack in IDLE is ignored
    m_ack = 1'b1; m_rdata = 32'hCAFE_CAFE;
    cyc();
    m_ack = 1'b0;
    chk_bit ("idle ack i_rvalid", i_rvalid, 1'b0);
    chk_bit ("idle ack d_rvalid", d_rvalid, 1'b0);
    chk_bit ("idle ack m_req",    m_req,    1'b0);

    // ---- reset while a load is in flight, then a late ack
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    cyc();                                                    // c1
    chk_bit ("rmid d_gnt", d_gnt, 1'b1);
    chk_bit ("rmid m_req", m_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_bit ("rmid m_req async", m_req, 1'b0);
    chk_bit ("rmid d_gnt async", d_gnt, 1'b0);
    cyc();
    reset = 1'b0; d_req = 1'b0;
    m_ack = 1'b1; m_rdata = 32'h99;                           // late ack
    cyc();
    m_ack = 1'b0;
    chk_bit ("rmid no d_rvalid", d_rvalid, 1'b0);
    chk_bit ("rmid m_req idle",  m_req,    1'b0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;              // fresh c0
    cyc();                                                    // c1
    chk_bit ("post d_gnt",  d_gnt, 1'b1);
    chk_word("post m_addr", m_addr, 32'h500);
    m_ack = 1'b1; m_rdata = 32'h5; d_req = 1'b0;
    cyc();
    m_ack = 1'b0;
    chk_bit ("post d_rvalid", d_rvalid, 1'b1);
    chk_word("post d_rdata",  d_rdata,  32'h5);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
